// File: rtl/ps2_move_decoder_if.sv
// Pin-side and decoded-output bundle for the PS/2 movement decoder.
// scancode_valid is a one-cycle strobe with no ready/backpressure; consumers must take scancode that cycle.
interface ps2_move_decoder_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic       move_up;
  logic       move_down;
  logic       move_right;
  logic       move_left;
  logic [7:0] scancode;
  logic       scancode_valid;
  logic       frame_err;
  logic [1:0] rx_state;

  modport master (
    output ps2_clk, ps2_data,
    input  move_up, move_down, move_right, move_left,
    input  scancode, scancode_valid, frame_err, rx_state
  );

  modport slave (
    input  ps2_clk, ps2_data,
    output move_up, move_down, move_right, move_left,
    output scancode, scancode_valid, frame_err, rx_state
  );
endinterface

// File: rtl/ps2_move_decoder.sv
// PS/2 set-2 receiver with WASD/arrow make-break decoding into held direction levels.
// rx_state on the bus exposes the receive FSM state (0 IDLE, 1 DATA, 2 PARITY, 3 STOP).
module ps2_move_decoder #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic             clk,
  input  logic             rst,
  ps2_move_decoder_if.slave bus
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } rx_state_t;

  // Synchronizers idle high so reset never fabricates a falling edge.
  logic clk_s1, clk_s2, dat_s1, dat_s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= bus.ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= bus.ps2_data;
      dat_s2 <= dat_s1;
    end
  end

  logic          fclk;
  logic [FW-1:0] flt_cnt;
  logic          fall;
  logic          fall_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fclk      <= 1'b1;
      flt_cnt   <= '0;
      fall      <= 1'b0;
      fall_data <= 1'b1;
    end else begin
      fall <= 1'b0;
      if (clk_s2 == fclk) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
        fclk      <= clk_s2;
        flt_cnt   <= '0;
        fall      <= ~clk_s2;
        fall_data <= dat_s2;
      end else begin
        flt_cnt <= flt_cnt + FW'(1);
      end
    end
  end

  rx_state_t     state, state_nxt;
  logic [7:0]    shift;
  logic [2:0]    bit_cnt;
  logic          par_bit;
  logic [TW-1:0] to_cnt;
  logic          timeout;
  logic          par_ok;
  logic          shift_en, par_en, byte_ok, byte_bad;
  logic [7:0]    scancode_q;
  logic          valid_q, err_q;

  assign timeout = (state != S_IDLE) && (to_cnt == TW'(TIMEOUT_CYCLES));
  assign par_ok  = ^{shift, par_bit};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (fall && !fall_data) state_nxt = S_DATA;
      S_DATA:   if (timeout) state_nxt = S_IDLE;
                else if (fall && bit_cnt == 3'd7) state_nxt = S_PARITY;
      S_PARITY: if (timeout) state_nxt = S_IDLE;
                else if (fall) state_nxt = S_STOP;
      S_STOP:   if (timeout || fall) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // A timeout wins over a coincident fall so an aborted frame is never half-accepted.
  always_comb begin
    shift_en = 1'b0;
    par_en   = 1'b0;
    byte_ok  = 1'b0;
    byte_bad = timeout;
    case (state)
      S_DATA:   shift_en = fall && !timeout;
      S_PARITY: par_en   = fall && !timeout;
      S_STOP: begin
        if (fall && !timeout) begin
          byte_ok  = fall_data && par_ok;
          byte_bad = !(fall_data && par_ok);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift      <= '0;
      bit_cnt    <= '0;
      par_bit    <= 1'b0;
      to_cnt     <= '0;
      scancode_q <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      valid_q <= byte_ok;
      err_q   <= byte_bad;
      if (byte_ok) scancode_q <= shift;

      if (state == S_IDLE || fall) to_cnt <= '0;
      else if (to_cnt != TW'(TIMEOUT_CYCLES)) to_cnt <= to_cnt + TW'(1);

      if (state == S_IDLE) begin
        bit_cnt <= '0;
        shift   <= '0;
      end else if (shift_en) begin
        bit_cnt <= bit_cnt + 3'd1;
        shift   <= {fall_data, shift[7:1]};
      end

      if (par_en) par_bit <= fall_data;
    end
  end

  // Held bits are indexed 0 up, 1 down, 2 right, 3 left in both tables.
  logic       ext_pend, brk_pend;
  logic [3:0] held_wasd, held_arrow;
  logic       hit;
  logic [1:0] idx;

  always_comb begin
    hit = 1'b0;
    idx = 2'd0;
    if (!ext_pend) begin
      case (scancode_q)
        8'h1D:   begin hit = 1'b1; idx = 2'd0; end
        8'h1B:   begin hit = 1'b1; idx = 2'd1; end
        8'h23:   begin hit = 1'b1; idx = 2'd2; end
        8'h1C:   begin hit = 1'b1; idx = 2'd3; end
        default: ;
      endcase
    end else begin
      case (scancode_q)
        8'h75:   begin hit = 1'b1; idx = 2'd0; end
        8'h72:   begin hit = 1'b1; idx = 2'd1; end
        8'h74:   begin hit = 1'b1; idx = 2'd2; end
        8'h6B:   begin hit = 1'b1; idx = 2'd3; end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ext_pend   <= 1'b0;
      brk_pend   <= 1'b0;
      held_wasd  <= '0;
      held_arrow <= '0;
    end else if (err_q) begin
      ext_pend <= 1'b0;
      brk_pend <= 1'b0;
    end else if (valid_q) begin
      case (scancode_q)
        8'hE0: ext_pend <= 1'b1;
        8'hF0: brk_pend <= 1'b1;
        default: begin
          ext_pend <= 1'b0;
          brk_pend <= 1'b0;
          if (hit) begin
            if (ext_pend) held_arrow[idx] <= ~brk_pend;
            else          held_wasd[idx]  <= ~brk_pend;
          end
        end
      endcase
    end
  end

  assign bus.move_up        = held_wasd[0] | held_arrow[0];
  assign bus.move_down      = held_wasd[1] | held_arrow[1];
  assign bus.move_right     = held_wasd[2] | held_arrow[2];
  assign bus.move_left      = held_wasd[3] | held_arrow[3];
  assign bus.scancode       = scancode_q;
  assign bus.scancode_valid = valid_q;
  assign bus.frame_err      = err_q;
  assign bus.rx_state       = state;

endmodule

// File: tb/tb_ps2_move_decoder.sv
// Directed bench: bit-bangs PS/2 frames and checks scancodes, errors and held direction levels.
module tb_ps2_move_decoder;

  localparam int FLT  = 8;
  localparam int TO   = 500;
  localparam int HALF = 20;
  localparam int GAP  = 30;

  logic clk;
  logic rst;

  ps2_move_decoder_if bus ();

  ps2_move_decoder #(
    .FILTER_LEN     (FLT),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_valid  = 0;
  int n_err    = 0;
  int v0, e0, lat_k;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_moves(input string tag, input logic [3:0] exp);
    check(tag, 32'({bus.move_up, bus.move_down, bus.move_right, bus.move_left}), 32'(exp));
  endtask

  // Scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.scancode_valid || bus.frame_err)
        check("valid_err_excl", 32'(bus.scancode_valid & bus.frame_err), 32'd0);
      if (bus.frame_err) n_err++;
      if (bus.scancode_valid) begin
        n_valid++;
        check("exp_q_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("scancode", 32'(bus.scancode), 32'(exp_q.pop_front()));
      end
    end
  end

  // Driver tasks
  task automatic ps2_bit(input logic b);
    bus.ps2_data = b;
    repeat (HALF) @(negedge clk);
    bus.ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    bus.ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
    logic par;
    par = (~^b) ^ bad_par;
    if (!bad_par && !bad_stop) exp_q.push_back(b);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(par);
    ps2_bit(~bad_stop);
    bus.ps2_data = 1'b1;
    repeat (GAP) @(negedge clk);
  endtask

  task automatic send_partial(input logic [7:0] b, input int nbits);
    ps2_bit(1'b0);
    for (int i = 0; i < nbits; i++) ps2_bit(b[i]);
  endtask

  initial begin
    rst = 1'b1;
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    repeat (5) @(negedge clk);
    check_moves("reset_moves", 4'b0000);
    check("reset_scancode", 32'(bus.scancode), 32'd0);
    check("reset_valid", 32'(bus.scancode_valid), 32'd0);
    check("reset_err", 32'(bus.frame_err), 32'd0);
    check("reset_state", 32'(bus.rx_state), 32'd0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // Make/break W with one-cycle move latency
    v0 = n_valid;
    fork
      send_frame(8'h1D, 1'b0, 1'b0);
      begin
        lat_k = 0;
        while (!bus.scancode_valid && lat_k < 2000) begin
          @(negedge clk);
          lat_k++;
        end
        check("valid_seen", 32'(lat_k < 2000), 32'd1);
        check("move_up_at_valid", 32'(bus.move_up), 32'd0);
        @(negedge clk);
        check("move_up_after_valid", 32'(bus.move_up), 32'd1);
      end
    join
    check_moves("w_make", 4'b1000);
    send_frame(8'hF0, 1'b0, 1'b0);
    check_moves("w_break_prefix", 4'b1000);
    send_frame(8'h1D, 1'b0, 1'b0);
    check_moves("w_break", 4'b0000);
    check("w_valid_count", 32'(n_valid - v0), 32'd3);

    // Extended arrows overlapping with A
    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'h74, 1'b0, 1'b0);
    check_moves("right_arrow_make", 4'b0010);
    send_frame(8'h1C, 1'b0, 1'b0);
    check_moves("a_and_right", 4'b0011);
    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h74, 1'b0, 1'b0);
    check_moves("right_arrow_break", 4'b0001);

    // Parity error
    v0 = n_valid;
    e0 = n_err;
    send_frame(8'h1B, 1'b1, 1'b0);
    check("par_err_count", 32'(n_err - e0), 32'd1);
    check("par_valid_count", 32'(n_valid - v0), 32'd0);
    check_moves("par_no_down", 4'b0001);
    send_frame(8'h1B, 1'b0, 1'b0);
    check_moves("s_make", 4'b0101);

    // Frame error cancels a pending break
    e0 = n_err;
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h23, 1'b0, 1'b1);
    check("stop_err_count", 32'(n_err - e0), 32'd1);
    send_frame(8'h23, 1'b0, 1'b0);
    check_moves("prefix_abort", 4'b0111);

    // Timeout mid-frame
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0);
    check_moves("a_break", 4'b0110);
    e0 = n_err;
    v0 = n_valid;
    send_partial(8'h1C, 4);
    bus.ps2_data = 1'b1;
    repeat (TO + 10 + HALF) @(negedge clk);
    check("timeout_err_count", 32'(n_err - e0), 32'd1);
    check("timeout_valid_count", 32'(n_valid - v0), 32'd0);
    check("timeout_idle", 32'(bus.rx_state), 32'd0);
    send_frame(8'h1C, 1'b0, 1'b0);
    check_moves("after_timeout", 4'b0111);
    check("after_timeout_code", 32'(bus.scancode), 32'h1C);

    // Short low glitches on ps2_clk with data low
    e0 = n_err;
    v0 = n_valid;
    bus.ps2_data = 1'b0;
    for (int g = 0; g < 4; g++) begin
      bus.ps2_clk = 1'b0;
      repeat (3) @(negedge clk);
      bus.ps2_clk = 1'b1;
      repeat (10) @(negedge clk);
    end
    bus.ps2_data = 1'b1;
    check("glitch_state", 32'(bus.rx_state), 32'd0);
    check("glitch_events", 32'((n_err - e0) + (n_valid - v0)), 32'd0);
    check_moves("glitch_moves", 4'b0111);

    // Asynchronous reset mid-frame
    send_frame(8'h1D, 1'b0, 1'b0);
    check_moves("w_before_reset", 4'b1111);
    send_partial(8'h1B, 3);
    check("midframe_state", 32'(bus.rx_state), 32'd1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_moves("async_reset_moves", 4'b0000);
    check("async_reset_code", 32'(bus.scancode), 32'd0);
    check("async_reset_flags", 32'({bus.scancode_valid, bus.frame_err}), 32'd0);
    check("async_reset_state", 32'(bus.rx_state), 32'd0);
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    send_frame(8'h1B, 1'b0, 1'b0);
    check_moves("post_reset_s", 4'b0100);
    check("post_reset_code", 32'(bus.scancode), 32'h1B);

    // Final report
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
